// File: rtl/relay_seq_pkg.sv
// Shared types, standard instruction lengths and the length-sanitising helper
// for the relay computer step sequencer.
package relay_seq_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_WAIT
    } seq_state_e;

    localparam int unsigned LEN_8  = 8;
    localparam int unsigned LEN_10 = 10;
    localparam int unsigned LEN_12 = 12;
    localparam int unsigned LEN_14 = 14;
    localparam int unsigned LEN_24 = 24;

    // 0 or over-long lengths run the full window; short ones still cover fetch plus one step.
    function automatic int unsigned sanitize_len(input int unsigned len,
                                                 input int unsigned num_steps,
                                                 input int unsigned fetch_steps);
        if (len == 0 || len > num_steps) begin
            return num_steps;
        end
        if (len < fetch_steps + 1) begin
            return fetch_steps + 1;
        end
        return len;
    endfunction

endpackage

// File: rtl/relay_seq_ring.sv
// One-hot step ring with clear/restart/advance controls and the one-step
// overlap ("prime") vector built from the previously held step.
module relay_seq_ring
    import relay_seq_pkg::*;
#(
    parameter int unsigned NUM_STEPS = 24
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 advance,
    input  logic                 restart,
    input  logic                 clear,
    output logic [NUM_STEPS-1:0] step_oh,
    output logic [NUM_STEPS-1:0] step_prime
);

    logic [NUM_STEPS-1:0] step_q, step_d;
    logic [NUM_STEPS-1:0] last_q, last_d;

    always_comb begin
        step_d = step_q;
        last_d = last_q;
        if (clear) begin
            step_d = '0;
        end else if (restart) begin
            step_d = {{(NUM_STEPS-1){1'b0}}, 1'b1};
        end else if (advance) begin
            step_d = {step_q[NUM_STEPS-2:0], 1'b0};
        end
        // Idle keeps clear asserted, so last_q drains to zero one cycle after entry.
        if (clear || restart || advance) begin
            last_d = step_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            step_q <= '0;
            last_q <= '0;
        end else begin
            step_q <= step_d;
            last_q <= last_d;
        end
    end

    assign step_oh    = step_q;
    assign step_prime = step_q | last_q;

endmodule

// File: rtl/relay_sequencer.sv
// Variable-length instruction step sequencer with run/halt control and a
// retired-instruction counter. Single-step WAIT state under RELAY_SEQ_SINGLE_STEP_EN.
module relay_sequencer
    import relay_seq_pkg::*;
#(
    parameter int unsigned NUM_STEPS   = 24,
    parameter int unsigned FETCH_STEPS = 8,
    parameter int unsigned CNT_W       = 16,
    localparam int unsigned LEN_W      = $clog2(NUM_STEPS + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 halt_req,
    input  logic [LEN_W-1:0]     instr_len,
    input  logic                 step_mode,
    input  logic                 step_pulse,
    output logic [NUM_STEPS-1:0] step_oh,
    output logic [NUM_STEPS-1:0] step_prime,
    output logic                 busy,
    output logic                 halted,
    output logic                 instr_done,
    output logic [CNT_W-1:0]     instr_count
);

    seq_state_e           state_q, state_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 hp_q, hp_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ring_advance, ring_restart, ring_clear;
    logic                 do_step, at_final, mode_en, pulse_en;
    logic [NUM_STEPS-1:0] final_mask;

`ifdef RELAY_SEQ_SINGLE_STEP_EN
    assign mode_en  = step_mode;
    assign pulse_en = step_pulse;
`else
    logic unused_step;
    assign unused_step = step_mode ^ step_pulse;
    assign mode_en     = 1'b0;
    assign pulse_en    = 1'b0;
`endif

    assign final_mask = {{(NUM_STEPS-1){1'b0}}, 1'b1} << (len_q - LEN_W'(1));
    assign at_final   = |(step_oh & final_mask);

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        hp_d         = hp_q;
        cnt_d        = cnt_q;
        ring_advance = 1'b0;
        ring_restart = 1'b0;
        ring_clear   = 1'b0;
        do_step      = 1'b0;
        unique case (state_q)
            SEQ_IDLE: begin
                ring_clear = 1'b1;
                if (run && !halt_req && !hp_q) begin
                    state_d      = SEQ_RUN;
                    ring_clear   = 1'b0;
                    ring_restart = 1'b1;
                end
            end
            SEQ_RUN: begin
                hp_d = hp_q | halt_req;
                if (mode_en) begin
                    state_d = SEQ_WAIT;
                end else begin
                    do_step = 1'b1;
                end
            end
            SEQ_WAIT: begin
                hp_d = hp_q | halt_req;
                if (!mode_en) begin
                    state_d = SEQ_RUN;
                end else begin
                    do_step = pulse_en;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase

        if (do_step) begin
            if (at_final) begin
                cnt_d = cnt_q + CNT_W'(1);
                // A halt request seen on the final step itself still stops at this boundary.
                if (hp_q || halt_req) begin
                    state_d    = SEQ_IDLE;
                    hp_d       = 1'b0;
                    ring_clear = 1'b1;
                end else begin
                    ring_restart = 1'b1;
                end
            end else begin
                ring_advance = 1'b1;
                if (step_oh[FETCH_STEPS-1]) begin
                    len_d = LEN_W'(sanitize_len(32'(instr_len), NUM_STEPS, FETCH_STEPS));
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SEQ_IDLE;
            len_q   <= LEN_W'(NUM_STEPS);
            hp_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            hp_q    <= hp_d;
            cnt_q   <= cnt_d;
        end
    end

    relay_seq_ring #(
        .NUM_STEPS (NUM_STEPS)
    ) u_ring (
        .clock      (clock),
        .reset      (reset),
        .advance    (ring_advance),
        .restart    (ring_restart),
        .clear      (ring_clear),
        .step_oh    (step_oh),
        .step_prime (step_prime)
    );

    assign busy        = (state_q != SEQ_IDLE);
    assign halted      = (state_q == SEQ_IDLE);
    assign instr_done  = busy && at_final;
    assign instr_count = cnt_q;

endmodule
